// File: rtl/adsr_pkg.sv
// Shared constants for the ADSR envelope stage: state encoding, level ceiling
// and the unity gain value used by the compare scaler.
package adsr_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [15:0] LEVEL_MAX = 16'hFFFF;
    localparam logic [8:0]  GAIN_ONE  = 9'd256;

endpackage

// File: rtl/adsr_gain_scale.sv
// Combinational amplitude scaler: compare * gain / 256, where the gain is the
// upper byte of the envelope level with 8'hFF promoted to exact unity so that
// a full-scale envelope passes the compare value through untouched.
module adsr_gain_scale
    import adsr_pkg::*;
(
    input  logic [8:0] compare,
    input  logic [7:0] level_hi,
    output logic [8:0] scaled
);

    logic [8:0]  gain;
    logic [17:0] product;
    logic        unused_product_bits;

    // Gain selection and fixed-point multiply; only bits [16:8] carry the result
    always_comb begin
        gain    = (level_hi == 8'hFF) ? GAIN_ONE : {1'b0, level_hi};
        product = {9'd0, compare} * {9'd0, gain};
        scaled  = product[16:8];
    end

    // Bit 17 is always zero (511 * 256 < 2^17) and the low byte is truncated
    assign unused_product_bits = ^{product[17], product[7:0]};

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope between the waveform compare source and the PWM.
// The level steps once per i_tick; the compare value is scaled by the level
// and re-presented one clock later.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | silent, level 0, waiting for a gate rise
// ATTACK   | level climbs by ATTACK_STEP per tick up to LEVEL_MAX
// DECAY    | level falls by DECAY_STEP per tick down to SUSTAIN_LEVEL
// SUSTAIN  | level held while the gate stays high
// RELEASE  | level falls by RELEASE_STEP per tick down to 0, then IDLE
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd256,
    parameter logic [15:0] DECAY_STEP    = 16'd64,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter logic [15:0] RELEASE_STEP  = 16'd128
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_gate,
    input  logic        i_tick,
    input  logic [8:0]  i_compare,
    input  logic        i_compare_valid,
    output logic [8:0]  o_compare,
    output logic        o_compare_valid,
    output logic [15:0] o_level,
    output logic        o_busy
);

    logic [2:0]  r_state;
    logic [2:0]  nxt_state;
    logic [15:0] r_level;
    logic [15:0] nxt_level;
    logic        r_gate_d;
    logic        w_rise;
    logic        w_fall;
    logic [16:0] w_attack_sum;
    logic [16:0] w_decay_diff;
    logic [16:0] w_release_diff;
    logic [8:0]  w_scaled;

    assign w_rise = i_gate & ~r_gate_d;
    assign w_fall = ~i_gate & r_gate_d;

    // 17-bit step arithmetic so overflow and underflow are visible in bit 16
    assign w_attack_sum   = {1'b0, r_level} + {1'b0, ATTACK_STEP};
    assign w_decay_diff   = {1'b0, r_level} - {1'b0, DECAY_STEP};
    assign w_release_diff = {1'b0, r_level} - {1'b0, RELEASE_STEP};

    // Next state and level: gate edges win over ticks and freeze the level
    always_comb begin
        nxt_state = r_state;
        nxt_level = r_level;
        if (w_rise) begin
            // Retrigger keeps the current level so there is no click
            nxt_state = ST_ATTACK;
        end else if (w_fall && (r_state != ST_IDLE)) begin
            nxt_state = ST_RELEASE;
        end else if (i_tick) begin
            case (r_state)
                ST_IDLE: begin
                    nxt_state = ST_IDLE;
                end
                ST_ATTACK: begin
                    if (w_attack_sum >= {1'b0, LEVEL_MAX}) begin
                        nxt_level = LEVEL_MAX;
                        nxt_state = ST_DECAY;
                    end else begin
                        nxt_level = w_attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if (w_decay_diff[16] || (w_decay_diff[15:0] <= SUSTAIN_LEVEL)) begin
                        nxt_level = SUSTAIN_LEVEL;
                        nxt_state = ST_SUSTAIN;
                    end else begin
                        nxt_level = w_decay_diff[15:0];
                    end
                end
                ST_SUSTAIN: begin
                    nxt_state = ST_SUSTAIN;
                end
                ST_RELEASE: begin
                    if (w_release_diff[16] || (w_release_diff[15:0] == 16'd0)) begin
                        nxt_level = 16'd0;
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_level = w_release_diff[15:0];
                    end
                end
                default: begin
                    nxt_level = 16'd0;
                    nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Envelope state, level and gate history registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_level  <= 16'd0;
            r_gate_d <= 1'b0;
        end else begin
            r_state  <= nxt_state;
            r_level  <= nxt_level;
            r_gate_d <= i_gate;
        end
    end

    adsr_gain_scale u_gain_scale (
        .compare  (i_compare),
        .level_hi (r_level[15:8]),
        .scaled   (w_scaled)
    );

    // Output stage: capture the scaled value on valid, otherwise hold it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_compare       <= 9'd0;
            o_compare_valid <= 1'b0;
        end else if (i_compare_valid) begin
            o_compare       <= w_scaled;
            o_compare_valid <= 1'b1;
        end else begin
            o_compare_valid <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Amplitude-envelope stage between the sine/waveform compare source and the `pwm` block.
- A note gate drives an Attack/Decay/Sustain/Release level register, advanced once per PWM cycle on `pwm.o_cycle_end`.
- Scales the incoming 9-bit compare value by that level and re-presents it, registered, to `pwm.i_compare` / `pwm.i_compare_valid`.
- Gives notes from the note sequencer audible onset and decay instead of hard on/off.

Parameters:
- ATTACK_STEP, 16'd256, level increment per tick in ATTACK (must be nonzero).
- DECAY_STEP, 16'd64, level decrement per tick in DECAY (must be nonzero).
- SUSTAIN_LEVEL, 16'hC000, level held in SUSTAIN.
- RELEASE_STEP, 16'd128, level decrement per tick in RELEASE (must be nonzero).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_gate  input  1  note gate, level-sensitive, synchronous to i_clk.
- i_tick  input  1  envelope step strobe, one-cycle pulse (driven from pwm o_cycle_end).
- i_compare  input  9  unscaled compare value.
- i_compare_valid  input  1  i_compare qualifier.
- o_compare  output  9  scaled compare value.
- o_compare_valid  output  1  o_compare qualifier.
- o_level  output  16  current envelope level.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, level=0, r_gate_d=0, o_compare=0, o_compare_valid=0, o_busy=0.
- Gate edges: register i_gate into r_gate_d; rise = i_gate & ~r_gate_d; fall = ~i_gate & r_gate_d.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. o_busy = (state != IDLE).
- Edge priority (evaluated every clock, before tick handling):
  - rise, any state -> ATTACK.
  - fall, state not IDLE -> RELEASE.
  - In an edge cycle the level is unchanged even if i_tick=1.
- Retrigger: a rise during DECAY, SUSTAIN or RELEASE attacks from the current level; the level is never reset to 0.
- Tick handling (no edge, i_tick=1), all arithmetic 17-bit then clamped:
  - ATTACK: level += ATTACK_STEP. If sum >= 16'hFFFF, set level=16'hFFFF and go to DECAY.
  - DECAY: level -= DECAY_STEP. If result <= SUSTAIN_LEVEL (or underflows), set level=SUSTAIN_LEVEL and go to SUSTAIN.
  - SUSTAIN: no change.
  - RELEASE: level -= RELEASE_STEP. If result <= 0, set level=0 and go to IDLE.
  - IDLE: no change.
- Gate held low with no rise: remains IDLE. A gate pulse shorter than one tick still produces ATTACK then RELEASE (rise and fall are seen on separate clocks).
- Gain:
  - g = {1'b0, level[15:8]} + (level[15:8]==8'hFF ? 1 : 0), range 0..256.
  - product = i_compare * g (18 bits); scaled value = product[16:8].
  - Full scale passes i_compare unchanged; level 0 gives 0.
- Output pipeline, latency 1:
  - When i_compare_valid=1: o_compare <= scaled value computed with the level as registered at that edge; o_compare_valid <= 1.
  - Otherwise o_compare holds and o_compare_valid <= 0.
  - A continuous i_compare_valid=1 yields a continuous valid output.
- Reset mid-note: immediate return to the reset values; gate rises are seen again only after release (r_gate_d is cleared).

Decomposition:
- Shared package adsr_pkg:
  - state encoding constants (3-bit: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4);
  - LEVEL_MAX=16'hFFFF;
  - GAIN_ONE=9'd256.
- One sub-module, adsr_gain_scale: combinational 9-bit x level[15:8] -> 9-bit scaling, unit-tested separately.
- The FSM and level register stay in adsr_envelope.

Test Plan:
- Reset, then gate=0, ticks running -> state IDLE, o_level=0; i_compare=300 -> o_compare=0 one cycle after valid.
- Gate rise, tick every 64 clocks -> o_level reaches 16'hFFFF on the 256th tick, DECAY entered; i_compare=300 -> o_compare=300.
- Continue with gate held -> 16'hC000 reached on the 256th DECAY tick, SUSTAIN; i_compare=256 -> o_compare=192; level constant over 100 further ticks.
- Gate fall in SUSTAIN -> RELEASE; level reaches 0 after 384 ticks, state IDLE, o_busy=0.
- Gate re-rise when level=16'h8000 in RELEASE -> ATTACK resumes from 16'h8000 and reaches 16'hFFFF after 128 ticks; gate edge coincident with a tick -> level unchanged that cycle.
- Assert i_rst_n=0 mid-ATTACK (level=16'h4000) -> o_level=0, o_compare=0, o_compare_valid=0, o_busy=0 immediately, without waiting for a clock edge.
